// File: rtl/captura_operandos_fsm.sv
// Operand capture front-end: debounces KEY[1:0] and walks the user through A, B and opcode,
// then offers {a, b, cin, seletor} to the ULA path over a valid/ready handshake.
module captura_operandos_fsm #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 19
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] SW,
  input  logic [1:0] KEY,
  input  logic       op_ready,
  output logic [3:0] a,
  output logic [3:0] b,
  output logic       cin,
  output logic [2:0] seletor,
  output logic       op_valid,
  output logic [1:0] estado,
  output logic       erro,
  output logic       erro_led
);

  // state  | meaning
  // CAP_A  | waiting for operand A and carry-in
  // CAP_B  | waiting for operand B
  // CAP_OP | waiting for a legal opcode
  // ISSUE  | request offered to consumer, held until accepted

  typedef enum logic [1:0] {
    CAP_A  = 2'b00,
    CAP_B  = 2'b01,
    CAP_OP = 2'b10,
    ISSUE  = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  state_t           state;
  logic [1:0]       sync1, sync2, stable, press;
  logic [CNT_W-1:0] cnt [2];
  logic             conf_p, back_p, reject;
  logic [4:0]       unused_sw;

  assign unused_sw = {SW[9], SW[7:4]};

  // Debounce: counter runs only while the synced level disagrees with the accepted one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= 2'b11;
      sync2  <= 2'b11;
      stable <= 2'b11;
      press  <= 2'b00;
      cnt[0] <= '0;
      cnt[1] <= '0;
    end else begin
      sync1 <= KEY;
      sync2 <= sync1;
      for (int i = 0; i < 2; i++) begin
        press[i] <= 1'b0;
        if (sync2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          stable[i] <= sync2[i];
          cnt[i]    <= '0;
          press[i]  <= stable[i] & ~sync2[i];
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  assign conf_p = press[0];
  assign back_p = press[1];
  assign reject = (SW[2:0] == 3'b111) || ((SW[2:0] == 3'b110) && (b == 4'd0));
  assign estado = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= CAP_A;
      a        <= '0;
      b        <= '0;
      cin      <= 1'b0;
      seletor  <= '0;
      op_valid <= 1'b0;
      erro     <= 1'b0;
      erro_led <= 1'b0;
    end else begin
      erro <= 1'b0;
      case (state)
        CAP_A: begin
          if (conf_p && !back_p) begin
            a        <= SW[3:0];
            cin      <= SW[8];
            erro_led <= 1'b0;
            state    <= CAP_B;
          end
        end
        CAP_B: begin
          if (back_p) begin
            state <= CAP_A;
          end else if (conf_p) begin
            b        <= SW[3:0];
            erro_led <= 1'b0;
            state    <= CAP_OP;
          end
        end
        CAP_OP: begin
          if (back_p) begin
            state <= CAP_B;
          end else if (conf_p) begin
            if (reject) begin
              erro     <= 1'b1;
              erro_led <= 1'b1;
            end else begin
              seletor  <= SW[2:0];
              erro_led <= 1'b0;
              op_valid <= 1'b1;
              state    <= ISSUE;
            end
          end
        end
        ISSUE: begin
          // keys are deliberately ignored: a posted request cannot be withdrawn
          if (op_ready) begin
            op_valid <= 1'b0;
            state    <= CAP_A;
          end
        end
        default: state <= CAP_A;
      endcase
    end
  end

endmodule

// File: tb/tb_captura_operandos_fsm.sv
// Directed bench for captura_operandos_fsm with a short debounce window.
module tb_captura_operandos_fsm;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] SW = '0;
  logic [1:0] KEY = 2'b11;
  logic       op_ready = 1'b0;
  logic [3:0] a, b;
  logic       cin;
  logic [2:0] seletor;
  logic       op_valid;
  logic [1:0] estado;
  logic       erro, erro_led;

  int vectors = 0;
  int miscompares = 0;
  int valid_cnt = 0;
  int xfer_cnt = 0;
  int erro_cnt = 0;

  captura_operandos_fsm #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .SW(SW), .KEY(KEY), .op_ready(op_ready),
    .a(a), .b(b), .cin(cin), .seletor(seletor), .op_valid(op_valid),
    .estado(estado), .erro(erro), .erro_led(erro_led)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (op_valid) valid_cnt++;
    if (op_valid && op_ready) xfer_cnt++;
    if (erro) erro_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input logic [1:0] mask);
    KEY = ~mask;
    tick(8);
    KEY = 2'b11;
    tick(8);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(2);
    vectors++;
    if ({estado, a, b, cin, seletor, op_valid, erro, erro_led} !== 17'd0) begin
      miscompares++;
      $display("FAIL reset_state: got estado=%0d a=%0d b=%0d cin=%0d sel=%0d v=%0d e=%0d led=%0d, want all 0",
               estado, a, b, cin, seletor, op_valid, erro, erro_led);
    end
  endtask

  task automatic test_full_entry();
    int v0, x0;
    op_ready = 1'b1;
    SW = 10'h100 | 10'd5;
    press(2'b01);
    vectors++;
    if (estado !== 2'b01 || a !== 4'd5 || cin !== 1'b1) begin
      miscompares++;
      $display("FAIL entry_a: got estado=%0d a=%0d cin=%0d, want 1 5 1", estado, a, cin);
    end
    SW = 10'd3;
    press(2'b01);
    vectors++;
    if (estado !== 2'b10 || b !== 4'd3) begin
      miscompares++;
      $display("FAIL entry_b: got estado=%0d b=%0d, want 2 3", estado, b);
    end
    SW = 10'd0;
    v0 = valid_cnt;
    x0 = xfer_cnt;
    press(2'b01);
    vectors++;
    if (valid_cnt - v0 !== 1 || xfer_cnt - x0 !== 1) begin
      miscompares++;
      $display("FAIL entry_issue: got valid_cycles=%0d transfers=%0d, want 1 1", valid_cnt - v0, xfer_cnt - x0);
    end
    vectors++;
    if (estado !== 2'b00 || seletor !== 3'd0 || a !== 4'd5 || b !== 4'd3 || op_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL entry_done: got estado=%0d sel=%0d a=%0d b=%0d v=%0d, want 0 0 5 3 0",
               estado, seletor, a, b, op_valid);
    end
    op_ready = 1'b0;
  endtask

  task automatic test_bounce();
    SW = 10'd9;
    for (int i = 0; i < 5; i++) begin
      KEY[0] = 1'b0;
      tick(2);
      KEY[0] = 1'b1;
      tick(2);
    end
    tick(4);
    vectors++;
    if (estado !== 2'b00) begin
      miscompares++;
      $display("FAIL bounce_glitch: got estado=%0d, want 0", estado);
    end
    KEY[0] = 1'b0;
    tick(10);
    KEY[0] = 1'b1;
    tick(10);
    vectors++;
    if (estado !== 2'b01 || a !== 4'd9 || cin !== 1'b0) begin
      miscompares++;
      $display("FAIL bounce_single: got estado=%0d a=%0d cin=%0d, want 1 9 0", estado, a, cin);
    end
  endtask

  task automatic test_reject();
    int e0;
    SW = 10'd0;
    press(2'b01);
    e0 = erro_cnt;
    SW = 10'd6;
    press(2'b01);
    vectors++;
    if (erro_cnt - e0 !== 1 || erro_led !== 1'b1 || estado !== 2'b10 || seletor !== 3'd0) begin
      miscompares++;
      $display("FAIL reject_div0: got erro_pulses=%0d led=%0d estado=%0d sel=%0d, want 1 1 2 0",
               erro_cnt - e0, erro_led, estado, seletor);
    end
    SW = 10'd7;
    press(2'b01);
    vectors++;
    if (erro_cnt - e0 !== 2 || erro_led !== 1'b1 || estado !== 2'b10) begin
      miscompares++;
      $display("FAIL reject_111: got erro_pulses=%0d led=%0d estado=%0d, want 2 1 2", erro_cnt - e0, erro_led, estado);
    end
    SW = 10'd2;
    press(2'b01);
    vectors++;
    if (estado !== 2'b11 || erro_led !== 1'b0 || seletor !== 3'd2 || op_valid !== 1'b1 || erro_cnt - e0 !== 2) begin
      miscompares++;
      $display("FAIL reject_accept: got estado=%0d led=%0d sel=%0d v=%0d erro_pulses=%0d, want 3 0 2 1 2",
               estado, erro_led, seletor, op_valid, erro_cnt - e0);
    end
  endtask

  task automatic test_back_pressure();
    int bad = 0;
    int x0;
    x0 = xfer_cnt;
    for (int i = 0; i < 50; i++) begin
      SW = 10'($urandom_range(0, 1023));
      KEY[0] = !(i >= 5 && i < 15) && !(i >= 32 && i < 40);
      KEY[1] = !(i >= 20 && i < 28) && !(i >= 32 && i < 40);
      tick(1);
      if (op_valid !== 1'b1 || estado !== 2'b11 || a !== 4'd9 || b !== 4'd0 || seletor !== 3'd2 || cin !== 1'b0) bad++;
    end
    KEY = 2'b11;
    vectors++;
    if (bad !== 0 || xfer_cnt !== x0) begin
      miscompares++;
      $display("FAIL bp_hold: got bad_cycles=%0d transfers=%0d, want 0 0", bad, xfer_cnt - x0);
    end
    op_ready = 1'b1;
    tick(1);
    vectors++;
    if (op_valid !== 1'b0 || estado !== 2'b00 || xfer_cnt - x0 !== 1) begin
      miscompares++;
      $display("FAIL bp_transfer: got v=%0d estado=%0d transfers=%0d, want 0 0 1", op_valid, estado, xfer_cnt - x0);
    end
    op_ready = 1'b0;
    tick(4);
    vectors++;
    if (estado !== 2'b00 || op_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_after: got estado=%0d v=%0d, want 0 0", estado, op_valid);
    end
  endtask

  task automatic test_back_nav();
    SW = 10'd12;
    press(2'b01);
    SW = 10'd1;
    press(2'b01);
    press(2'b10);
    vectors++;
    if (estado !== 2'b01) begin
      miscompares++;
      $display("FAIL back_op: got estado=%0d, want 1", estado);
    end
    press(2'b10);
    vectors++;
    if (estado !== 2'b00 || a !== 4'd12) begin
      miscompares++;
      $display("FAIL back_b: got estado=%0d a=%0d, want 0 12", estado, a);
    end
    press(2'b10);
    vectors++;
    if (estado !== 2'b00) begin
      miscompares++;
      $display("FAIL back_a: got estado=%0d, want 0", estado);
    end
    SW = 10'd7;
    press(2'b01);
    SW = 10'd8;
    press(2'b11);
    vectors++;
    if (estado !== 2'b00 || b !== 4'd1 || a !== 4'd7) begin
      miscompares++;
      $display("FAIL back_both: got estado=%0d a=%0d b=%0d, want 0 7 1", estado, a, b);
    end
  endtask

  task automatic test_async_reset();
    op_ready = 1'b0;
    SW = 10'h104;
    press(2'b01);
    press(2'b01);
    press(2'b01);
    vectors++;
    if (estado !== 2'b11 || op_valid !== 1'b1 || seletor !== 3'd4) begin
      miscompares++;
      $display("FAIL arst_setup: got estado=%0d v=%0d sel=%0d, want 3 1 4", estado, op_valid, seletor);
    end
    #3;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({estado, a, b, cin, seletor, op_valid, erro, erro_led} !== 17'd0) begin
      miscompares++;
      $display("FAIL arst_clear: got estado=%0d a=%0d b=%0d cin=%0d sel=%0d v=%0d, want all 0",
               estado, a, b, cin, seletor, op_valid);
    end
    tick(2);
    rst_n = 1'b1;
    tick(3);
    vectors++;
    if (estado !== 2'b00 || op_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL arst_release: got estado=%0d v=%0d, want 0 0", estado, op_valid);
    end
  endtask

  initial begin
    test_reset();
    test_full_entry();
    test_bounce();
    test_reject();
    test_back_pressure();
    test_back_nav();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/captura_operandos_fsm.md
Name: captura_operandos_fsm

Overview:
- Sequential front-end that turns raw board inputs (SW, active-low KEY) into a registered operation request for the ULA datapath.
- Debounces both keys and steps the user through entering A, then B, then the operation code.
- Presents {a, b, cin, seletor} to the consumer with a valid/ready handshake; the consumer is the ULA/display path.

Parameters:
- DEBOUNCE_CYCLES, 500000, clock cycles a synchronized key level must stay unchanged before it is accepted (10 ms at 50 MHz).
- CNT_W, 19, width of each debounce counter; must satisfy 2^CNT_W >= DEBOUNCE_CYCLES.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- SW  input  10  raw slide switches; SW[3:0] data nibble, SW[8] carry-in, SW[2:0] opcode.
- KEY  input  2  raw push-buttons, active-low; KEY[0] = confirm, KEY[1] = back.
- op_ready  input  1  consumer accepts the request.
- a  output  4  captured operand A.
- b  output  4  captured operand B.
- cin  output  1  captured carry-in.
- seletor  output  3  captured opcode, same encoding as the ULA mux (000 soma … 110 divisao).
- op_valid  output  1  request valid.
- estado  output  2  current state, for the HEX5 prompt.
- erro  output  1  one-cycle pulse on a rejected confirm.
- erro_led  output  1  sticky error flag.

Behaviour:
- Reset (async, rst_n=0):
  - a, b, cin, seletor, op_valid, erro, erro_led = 0.
  - estado = CAP_A.
  - Debounced key levels = 1 (released); counters = 0; synchronizers = 1.
- Key conditioning, per key:
  - 2-flop synchronizer.
  - Counter clears whenever the synced level equals the stable level, and increments otherwise.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, the stable level takes the synced value and the counter clears.
  - Press pulse (1 cycle) when the stable level goes 1->0. Release generates nothing.
  - Glitches shorter than DEBOUNCE_CYCLES produce no pulse.
- FSM states, with the estado encoding:
  - CAP_A = 00:
    - Confirm: a <= SW[3:0], cin <= SW[8], go to CAP_B.
    - Back: ignored.
  - CAP_B = 01:
    - Confirm: b <= SW[3:0], go to CAP_OP.
    - Back: go to CAP_A; a is kept until overwritten.
  - CAP_OP = 10, confirm is rejected when:
    - SW[2:0] = 111 (unused), or
    - SW[2:0] = 110 and b = 0 (divide by zero).
  - On rejection: erro = 1 for one cycle, erro_led = 1, stay in CAP_OP, seletor unchanged.
  - Otherwise: seletor <= SW[2:0], go to ISSUE.
  - Back from CAP_OP: go to CAP_B.
  - ISSUE = 11:
    - op_valid = 1 as a registered output, asserted in the cycle the state is entered.
    - a, b, cin, seletor are held constant while op_valid = 1.
    - Transfer happens in the cycle op_valid & op_ready; the next cycle has op_valid = 0 and estado = CAP_A.
    - Confirm and back are both ignored in ISSUE; a request cannot be withdrawn.
- Any accepted confirm clears erro_led.
- Confirm and back pulses in the same cycle: back wins and confirm is discarded. In ISSUE, both are ignored.
- op_ready is ignored outside ISSUE.
- Pulse-to-state latency: a press pulse in cycle n updates the state and registers at edge n+1.
- Raw-press latency: about 2 + DEBOUNCE_CYCLES cycles from a stable raw falling edge to the pulse.
- Reset asserted mid-operation, including during ISSUE: all outputs clear immediately (asynchronously); no partial handshake survives.

Test Plan (simulate with DEBOUNCE_CYCLES=4):
1. Full entry:
   - Stimulus: SW[3:0]=5, SW[8]=1, press KEY0; SW[3:0]=3, KEY0; SW[2:0]=000, KEY0; op_ready held 1.
   - Required: estado steps 00->01->10->11; a=5, cin=1, b=3, seletor=000; op_valid high exactly 1 cycle, then estado=00.
2. Bounce filter:
   - Stimulus: KEY0 toggled with 2-cycle pulses for 20 cycles, then held low 10 cycles.
   - Required: exactly one confirm pulse; estado advances by one.
3. Rejection:
   - 3a: in CAP_OP with b=0, SW[2:0]=110, confirm -> erro pulse, erro_led=1, estado stays 10.
   - 3b: then SW[2:0]=111, confirm -> erro again.
   - 3c: then SW[2:0]=010, confirm -> ISSUE, erro_led=0.
4. Back-pressure:
   - Stimulus: in ISSUE with op_ready=0 for 50 cycles; toggle SW and press both keys meanwhile.
   - Required: op_valid stays 1; a, b, seletor unchanged; the transfer occurs on the first cycle op_ready=1.
5. Back navigation:
   - 5a: CAP_OP, back -> CAP_B; back -> CAP_A; back -> CAP_A.
   - 5b: simultaneous confirm+back pulses in CAP_B -> CAP_A.
6. Async reset during ISSUE:
   - Stimulus: drop rst_n mid-cycle while op_valid=1.
   - Required: op_valid=0 and all outputs 0 before the next clk edge; estado=00 after release.
